// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam int NCH    = 8;
    localparam int SEL_W  = 3;
    localparam int DATA_W = 8;

    // Next channel in the scan order; the 3-bit arithmetic wraps 7->0 and 0->7.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel, input logic down);
        logic [SEL_W-1:0] nxt;
        if (down) begin
            nxt = sel - 3'd1;
        end else begin
            nxt = sel + 3'd1;
        end
        return nxt;
    endfunction

    // Channel that closes a frame: 7 when counting up, 0 when counting down.
    function automatic logic is_last_sel(input logic [SEL_W-1:0] sel, input logic down);
        logic last;
        if (down) begin
            last = (sel == 3'd0);
        end else begin
            last = (sel == 3'd7);
        end
        return last;
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_reg.sv
// 8-bit data register with write enable and asynchronous active-low clear.
module eight_bit_reg_en
    import mux_scan_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;

    // Capture write data when enabled; cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 8'h00;
        end else if (en_i) begin
            data_q <= d_i;
        end else begin
            data_q <= data_q;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/mux_scan_sequencer.sv
// Feeder for an 8-bit 8:1 mux: eight host-writable data registers plus a
// dwell-timed select sequencer that flags each channel's sample point.
// Optional feature macro: SCAN_DIR_EN adds a 'dir' input for down-count scans.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              cont,
`ifdef SCAN_DIR_EN
    input  logic              dir,
`endif
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] e,
    output logic [DATA_W-1:0] f,
    output logic [DATA_W-1:0] g,
    output logic [DATA_W-1:0] h,
    output logic              s0,
    output logic              s1,
    output logic              s2,
    output logic              ch_valid,
    output logic              done,
    output logic              busy
);

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    logic [DATA_W-1:0] regs_s [NCH];

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             cont_q, cont_d;
    logic             down_q, down_d;
    logic             ch_valid_s;
    logic             done_s;
    logic             dir_s;

    for (genvar i = 0; i < NCH; i++) begin : g_reg
        eight_bit_reg_en u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (wr_en && (wr_addr == 3'(i))),
            .d_i   (wr_data),
            .q_o   (regs_s[i])
        );
    end

`ifdef SCAN_DIR_EN
    assign dir_s = dir;
`else
    assign dir_s = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            cont_q  <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            cont_q  <= cont_d;
            down_q  <= down_d;
        end
    end

    // Next-state and sample/done decode; stop outranks advance and wrap.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        cont_d     = cont_q;
        down_d     = down_q;
        ch_valid_s = 1'b0;
        done_s     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                sel_d = 3'd0;
                if (start && !stop) begin
                    state_d = SCAN;
                    cont_d  = cont;
                    down_d  = dir_s;
                    sel_d   = dir_s ? 3'd7 : 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                ch_valid_s = (cnt_q == DWELL_M1);
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    sel_d   = 3'd0;
                end else if (ch_valid_s) begin
                    cnt_d = 8'd0;
                    if (is_last_sel(sel_q, down_q) && !cont_q) begin
                        done_s  = 1'b1;
                        state_d = IDLE;
                        sel_d   = 3'd0;
                    end else begin
                        sel_d = next_sel(sel_q, down_q);
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                sel_d   = 3'd0;
            end
        endcase
    end

    assign a = regs_s[0];
    assign b = regs_s[1];
    assign c = regs_s[2];
    assign d = regs_s[3];
    assign e = regs_s[4];
    assign f = regs_s[5];
    assign g = regs_s[6];
    assign h = regs_s[7];

    assign s0       = sel_q[0];
    assign s1       = sel_q[1];
    assign s2       = sel_q[2];
    assign ch_valid = ch_valid_s;
    assign done     = done_s;
    assign busy     = (state_q == SCAN);

endmodule
